// File: rtl/mem_bus_ctrl.sv
// Bus controller from the CPU load/store port to NREG memory regions: one-hot region decode,
// posted writes, stalled reads. Define MEMBUS_PERF_CNT_EN to add read/stall performance counters.
module mem_bus_ctrl #(
    parameter int              DBUS    = 32,
    parameter int              ABUS    = 15,
    parameter int              RSEL    = 1,
    parameter int              NREG    = 2,
    parameter int              RD_LAT  = 1,
    parameter logic [DBUS-1:0] ERR_VAL = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ABUS-1:0]        cpu_addr,
    input  logic [DBUS-1:0]        cpu_wdata,
    input  logic                   cpu_we,
    input  logic                   cpu_re,
    output logic [DBUS-1:0]        cpu_rdata,
    output logic                   cpu_stall,
    output logic                   cpu_err,
    output logic [NREG-1:0]        mem_en,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [ABUS-RSEL-1:0]   mem_addr,
    output logic [DBUS-1:0]        mem_wdata,
    input  logic [NREG*DBUS-1:0]   mem_rdata
`ifdef MEMBUS_PERF_CNT_EN
    ,
    output logic [31:0]            rd_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int LW = ABUS - RSEL;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [RSEL-1:0] region;
    logic [RSEL-1:0] rd_sel;
    logic            in_range;
    logic [NREG-1:0] region_oh;
    logic [DBUS-1:0] rd_slice;

    assign region    = cpu_addr[ABUS-1 -: RSEL];
    assign in_range  = (32'(region) < 32'(NREG));
    assign cpu_stall = ((state == IDLE) && cpu_re && !cpu_we) || (state == RD_WAIT);

    // rd_sel remembers which region's data lane to capture at the end of the wait.
    always_comb begin
        region_oh = '0;
        rd_slice  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (region == RSEL'(i)) region_oh[i] = 1'b1;
            if (rd_sel == RSEL'(i)) rd_slice = mem_rdata[i*DBUS +: DBUS];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_sel    <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            mem_en    <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en  <= '0;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            cpu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_we) begin
                        // a read presented together with a write is dropped and flagged
                        cpu_err <= cpu_re || !in_range;
                        if (in_range) begin
                            mem_en    <= region_oh;
                            mem_we    <= 1'b1;
                            mem_addr  <= cpu_addr[LW-1:0];
                            mem_wdata <= cpu_wdata;
                        end
                    end else if (cpu_re) begin
                        if (in_range) begin
                            mem_en   <= region_oh;
                            mem_re   <= 1'b1;
                            mem_addr <= cpu_addr[LW-1:0];
                            rd_sel   <= region;
                            cnt      <= 4'(RD_LAT);
                            state    <= RD_WAIT;
                        end else begin
                            cpu_rdata <= ERR_VAL;
                            cpu_err   <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        cpu_rdata <= rd_slice;
                        state     <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMBUS_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state == RD_WAIT) && (cnt == 4'd1)) rd_cnt <= rd_cnt + 32'd1;
            if (cpu_stall) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: three instances cover default, RD_LAT=3 and 3-region/RSEL=2 builds.
module tb_mem_bus_ctrl;

    logic clk;
    logic rst;

    // instance A: defaults (RD_LAT=1)
    logic [14:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we, a_re;
    logic [31:0] a_rdata;
    logic        a_stall, a_err;
    logic [1:0]  a_en;
    logic        a_mwe, a_mre;
    logic [13:0] a_maddr;
    logic [31:0] a_mwdata;
    logic [63:0] a_mrdata;

    // instance B: RD_LAT=3
    logic [14:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_we, b_re;
    logic [31:0] b_rdata;
    logic        b_stall, b_err;
    logic [1:0]  b_en;
    logic        b_mwe, b_mre;
    logic [13:0] b_maddr;
    logic [31:0] b_mwdata;
    logic [63:0] b_mrdata;

    // instance C: NREG=3, RSEL=2
    logic [14:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_we, c_re;
    logic [31:0] c_rdata;
    logic        c_stall, c_err;
    logic [2:0]  c_en;
    logic        c_mwe, c_mre;
    logic [12:0] c_maddr;
    logic [31:0] c_mwdata;
    logic [95:0] c_mrdata;

`ifdef MEMBUS_PERF_CNT_EN
    logic [31:0] a_rdcnt, a_stcnt, b_rdcnt, b_stcnt, c_rdcnt, c_stcnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_bus_ctrl u_a (
        .clk(clk), .rst(rst), .cpu_addr(a_addr), .cpu_wdata(a_wdata), .cpu_we(a_we), .cpu_re(a_re),
        .cpu_rdata(a_rdata), .cpu_stall(a_stall), .cpu_err(a_err), .mem_en(a_en), .mem_we(a_mwe),
        .mem_re(a_mre), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata)
`ifdef MEMBUS_PERF_CNT_EN
        , .rd_cnt(a_rdcnt), .stall_cnt(a_stcnt)
`endif
    );

    mem_bus_ctrl #(.RD_LAT(3)) u_b (
        .clk(clk), .rst(rst), .cpu_addr(b_addr), .cpu_wdata(b_wdata), .cpu_we(b_we), .cpu_re(b_re),
        .cpu_rdata(b_rdata), .cpu_stall(b_stall), .cpu_err(b_err), .mem_en(b_en), .mem_we(b_mwe),
        .mem_re(b_mre), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata)
`ifdef MEMBUS_PERF_CNT_EN
        , .rd_cnt(b_rdcnt), .stall_cnt(b_stcnt)
`endif
    );

    mem_bus_ctrl #(.RSEL(2), .NREG(3)) u_c (
        .clk(clk), .rst(rst), .cpu_addr(c_addr), .cpu_wdata(c_wdata), .cpu_we(c_we), .cpu_re(c_re),
        .cpu_rdata(c_rdata), .cpu_stall(c_stall), .cpu_err(c_err), .mem_en(c_en), .mem_we(c_mwe),
        .mem_re(c_mre), .mem_addr(c_maddr), .mem_wdata(c_mwdata), .mem_rdata(c_mrdata)
`ifdef MEMBUS_PERF_CNT_EN
        , .rd_cnt(c_rdcnt), .stall_cnt(c_stcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] wa [4];
    logic [1:0]  we_en [4];

    initial begin
        wa    = '{15'h0000, 15'h4001, 15'h0002, 15'h4003};
        we_en = '{2'b01, 2'b10, 2'b01, 2'b10};
        clk = 1'b0;
        rst = 1'b0;
        a_addr = '0; a_wdata = '0; a_we = 1'b0; a_re = 1'b0; a_mrdata = '0;
        b_addr = '0; b_wdata = '0; b_we = 1'b0; b_re = 1'b0; b_mrdata = '0;
        c_addr = '0; c_wdata = '0; c_we = 1'b0; c_re = 1'b0; c_mrdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_en", a_en, 0);
        chk("rst_a_we", a_mwe, 0);
        chk("rst_a_re", a_mre, 0);
        chk("rst_a_addr", a_maddr, 0);
        chk("rst_a_wdata", a_mwdata, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_c_en", c_en, 0);
        rst = 1'b1;

        // posted write to region 1
        step(); a_addr = 15'h4010; a_wdata = 32'h0000ABCD; a_we = 1'b1;
        @(negedge clk); chk("wr_c0_stall", a_stall, 0);
        step(); a_we = 1'b0;
        @(negedge clk);
        chk("wr_en", a_en, 2'b10);
        chk("wr_we", a_mwe, 1);
        chk("wr_addr", a_maddr, 14'h0010);
        chk("wr_wdata", a_mwdata, 32'h0000ABCD);
        chk("wr_re", a_mre, 0);
        chk("wr_err", a_err, 0);
        chk("wr_c1_stall", a_stall, 0);
        step();
        @(negedge clk);
        chk("wr_c2_we", a_mwe, 0);
        chk("wr_c2_en", a_en, 0);

        // simultaneous write and read
        step(); a_addr = 15'h0008; a_wdata = 32'h11112222; a_we = 1'b1; a_re = 1'b1;
        @(negedge clk); chk("wr_rd_c0_stall", a_stall, 0);
        step(); a_we = 1'b0; a_re = 1'b0;
        @(negedge clk);
        chk("wr_rd_we", a_mwe, 1);
        chk("wr_rd_en", a_en, 2'b01);
        chk("wr_rd_re", a_mre, 0);
        chk("wr_rd_err", a_err, 1);
        chk("wr_rd_stall", a_stall, 0);
        chk("wr_rd_addr", a_maddr, 14'h0008);
        step();
        @(negedge clk);
        chk("wr_rd_c2_err", a_err, 0);
        chk("wr_rd_c2_we", a_mwe, 0);

        // four back-to-back writes then a read
        for (int k = 0; k < 5; k++) begin
            step();
            if (k < 4) begin
                a_we = 1'b1; a_re = 1'b0; a_addr = wa[k]; a_wdata = 32'(k + 1);
            end else begin
                a_we = 1'b0; a_re = 1'b1; a_addr = 15'h4020;
                a_mrdata = {32'hCAFEF00D, 32'h0BADBAD0};
            end
            @(negedge clk);
            if (k > 0) begin
                chk("b2b_we", a_mwe, 1);
                chk("b2b_en", a_en, we_en[k-1]);
                chk("b2b_addr", a_maddr, 14'(k - 1));
                chk("b2b_wdata", a_mwdata, 32'(k));
            end
            chk("b2b_stall", a_stall, (k == 4));
        end
        step();
        @(negedge clk);
        chk("b2b_rd_we", a_mwe, 0);
        chk("b2b_rd_re", a_mre, 1);
        chk("b2b_rd_en", a_en, 2'b10);
        chk("b2b_rd_stall", a_stall, 1);
        chk("b2b_rd_addr", a_maddr, 14'h0020);
        step(); a_re = 1'b0;
        @(negedge clk);
        chk("b2b_rd_done_stall", a_stall, 0);
        chk("b2b_rd_data", a_rdata, 32'hCAFEF00D);
        chk("b2b_rd_done_re", a_mre, 0);

        // read with RD_LAT=3
        step(); b_addr = 15'h0004; b_re = 1'b1; b_mrdata = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            if (c == 1) b_mrdata = {32'hAAAAAAAA, 32'h12345678};
            @(negedge clk);
            chk("lat3_stall", b_stall, 1);
            chk("lat3_re", b_mre, (c == 1));
            if (c == 1) begin
                chk("lat3_en", b_en, 2'b01);
                chk("lat3_addr", b_maddr, 14'h0004);
            end
        end
        step(); b_re = 1'b0;
        @(negedge clk);
        chk("lat3_done_stall", b_stall, 0);
        chk("lat3_data", b_rdata, 32'h12345678);
        chk("lat3_err", b_err, 0);

        // reset asserted mid-read in cycle 2
        step(); b_addr = 15'h0004; b_re = 1'b1; b_mrdata = {32'h0, 32'h55555555};
        step();
        step();
        #1 rst = 1'b0; b_re = 1'b0;
        #1;
        chk("mid_rst_rdata", b_rdata, 0);
        chk("mid_rst_en", b_en, 0);
        chk("mid_rst_re", b_mre, 0);
        chk("mid_rst_addr", b_maddr, 0);
        chk("mid_rst_err", b_err, 0);
        chk("mid_rst_stall", b_stall, 0);
        @(negedge clk); rst = 1'b1;
        repeat (4) begin
            step();
            @(negedge clk);
            chk("post_rst_rdata", b_rdata, 0);
            chk("post_rst_stall", b_stall, 0);
        end

        // out-of-range read with three regions
        step(); c_addr = 15'h6000; c_re = 1'b1;
        @(negedge clk); chk("oor_c0_stall", c_stall, 1);
        step(); c_re = 1'b0;
        @(negedge clk);
        chk("oor_stall", c_stall, 0);
        chk("oor_err", c_err, 1);
        chk("oor_rdata", c_rdata, 32'hDEADBEEF);
        chk("oor_en", c_en, 0);
        chk("oor_re", c_mre, 0);
        step();
        @(negedge clk); chk("oor_c2_err", c_err, 0);

        // in-range read of region 2
        step(); c_addr = 15'h4008; c_re = 1'b1; c_mrdata = {32'h22220002, 32'h11110001, 32'h0};
        @(negedge clk); chk("r2_c0_stall", c_stall, 1);
        step();
        @(negedge clk);
        chk("r2_en", c_en, 3'b100);
        chk("r2_re", c_mre, 1);
        chk("r2_stall", c_stall, 1);
        chk("r2_addr", c_maddr, 13'h0008);
        step(); c_re = 1'b0;
        @(negedge clk);
        chk("r2_done_stall", c_stall, 0);
        chk("r2_data", c_rdata, 32'h22220002);
        chk("r2_err", c_err, 0);

        // out-of-range write
        step(); c_addr = 15'h6004; c_wdata = 32'h1; c_we = 1'b1;
        @(negedge clk); chk("oow_stall", c_stall, 0);
        step(); c_we = 1'b0;
        @(negedge clk);
        chk("oow_err", c_err, 1);
        chk("oow_we", c_mwe, 0);
        chk("oow_en", c_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Parametrised memory-mapped bus controller between the Processor load/store port and NREG memory regions, such as program/data DataMemory and image Memory banks. It decodes the top RSEL address bits into a one-hot region enable. Writes are posted. Reads stall the CPU for a configurable read latency. Out-of-range accesses are flagged, which replaces the fixed single-bit address concatenation previously used to reach the image memory.

Parameters:
DBUS, 32, data width of CPU and memory ports
ABUS, 15, CPU address width
RSEL, 1, number of top address bits used as region index
NREG, 2, number of implemented regions (1..2^RSEL)
RD_LAT, 1, cycles from mem_re strobe to valid mem_rdata (1..15)
ERR_VAL, 32'hDEADBEEF, read data returned for out-of-range reads

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_addr  in  ABUS  CPU byte/word address
cpu_wdata  in  DBUS  store data
cpu_we  in  1  store request (MWE)
cpu_re  in  1  load request (MRE)
cpu_rdata  out  DBUS  load data, valid when cpu_stall low after a read
cpu_stall  out  1  CPU must hold request and inputs while high
cpu_err  out  1  one-cycle pulse on out-of-range or conflicting access
mem_en  out  NREG  one-hot region enable
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_addr  out  ABUS-RSEL  region-local address, cpu_addr[ABUS-RSEL-1:0]
mem_wdata  out  DBUS  write data to memories
mem_rdata  in  NREG*DBUS  read data, region r in bits [r*DBUS +: DBUS]

Behaviour:
- Region index r = cpu_addr[ABUS-1:ABUS-RSEL]. r >= NREG is out-of-range.
- All mem_* outputs, cpu_rdata and cpu_err are registered.
- cpu_stall = (state==IDLE & cpu_re & !cpu_we) | (state==RD_WAIT).
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE + cpu_we, in range:
  - Next cycle: mem_en[r]=1, mem_we=1, mem_addr and mem_wdata registered, for exactly 1 cycle.
  - State stays IDLE. No stall. Back-to-back writes every cycle are legal.
- IDLE + cpu_we, out of range: no strobe; cpu_err=1 next cycle.
- IDLE + cpu_re, in range:
  - Next cycle (cycle 1): mem_en[r]=1 and mem_re=1 for 1 cycle. State goes to RD_WAIT and a 4-bit counter loads RD_LAT.
  - RD_WAIT: counter decrements each cycle. When it reaches 1, mem_rdata slice r is captured into cpu_rdata and state goes to RESP.
  - RESP: stall low, cpu_rdata valid. Next edge always returns to IDLE; no request is accepted in RESP.
  - Total: stall high for cycles 0..RD_LAT, data valid in cycle RD_LAT+1.
- IDLE + cpu_re, out of range: no strobe; cpu_rdata=ERR_VAL and cpu_err=1, go directly to RESP (stall only in cycle 0).
- cpu_we and cpu_re both high: write executes, read is dropped, cpu_err=1 for 1 cycle.
- cpu_rdata holds its last value until the next read capture.
- Strobes are never asserted in RD_WAIT/RESP except the single cycle-1 read strobe.
- Reset (rst low, asynchronous): state=IDLE; cpu_rdata=0; cpu_err=0; mem_en=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0. Any read in flight is aborted; no RESP follows release.

Optional Feature:
MEMBUS_PERF_CNT_EN:
- Defined: adds outputs rd_cnt[31:0] (completed in-range reads) and stall_cnt[31:0] (cycles with cpu_stall=1). Both are reset to 0, wrap at 2^32, and are incremented in the same edge as the event.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: rst=0 mid-read (RD_LAT=3, cycle 2) -> all outputs 0 immediately, state IDLE, no cpu_rdata update after release.
2. Write to 15'h4010 with data 32'h0000ABCD, defaults -> next cycle mem_en=2'b10, mem_we=1, mem_addr=14'h0010, mem_wdata=32'h0000ABCD; stall never high.
3. Read at 15'h0004, RD_LAT=3, region0 returns 32'h12345678 three cycles after mem_re -> stall high cycles 0-3; cpu_rdata=32'h12345678 with stall low in cycle 4; mem_re high only in cycle 1.
4. NREG=3, RSEL=2, read at region 3 -> no mem_en; cpu_err=1; cpu_rdata=32'hDEADBEEF; stall high 1 cycle only.
5. Simultaneous cpu_we=1 and cpu_re=1 at 15'h0008 -> write strobe issued, no mem_re, cpu_err pulses 1 cycle, no stall.
6. Four back-to-back writes followed by a read (RD_LAT=1) -> four consecutive single-cycle mem_we strobes, then read completes with stall for cycles 0-1.
